mlu_ctrl: RTL and testbench
===========================

MLU_CTRL -- requirements
Module: mlu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk (rising edge) and reset; no other clocks or async resets.
REQ-002 Parameter ADDR_W, default 16, SHALL set the framebuffer tile address width.
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  draw command offered; cmd_ready  out  1  command accepted when both high.
REQ-006 cmd_addr  in  ADDR_W  base tile address; tile k (0..3) SHALL reside at cmd_addr+k mod 2^ADDR_W.
REQ-007 cmd_mask  in  512  tile k mask at bits [128k+127:128k]; cmd_primary, cmd_secondary  in  12 each  colours.
REQ-008 mem_rd_req  out  1; mem_rd_addr  out  ADDR_W; mem_rd_ack  in  1  request accepted this cycle.
REQ-009 mem_rd_valid  in  1; mem_rd_data  in  768  tile as {blues, greens, reds}, 256 bits each, returned in request order.
REQ-010 mem_wr_req  out  1; mem_wr_addr  out  ADDR_W; mem_wr_data  out  768; mem_wr_ack  in  1.
REQ-011 mlu_tiles  out  3072  tile k at [768k+767:768k]; mlu_mask  out  512; mlu_primary, mlu_secondary  out  12; mlu_next  in  3072  combinational MLU result, same packing.
REQ-012 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, READ, APPLY, WRITE, DONE.
REQ-014 IDLE: cmd_ready=1; on cmd_valid SHALL latch addr, mask, primary, secondary, clear counters, go READ.
REQ-015 cmd_ready SHALL be 0 in all states other than IDLE; commands offered then are not accepted.
REQ-016 READ: mem_rd_req=1 while issue count <4, mem_rd_addr = base+issue count; each ack SHALL increment issue count.
REQ-017 READ: each mem_rd_valid SHALL store mem_rd_data into tile slot[response count] and increment it; responses may arrive while requests still issue.
REQ-018 mem_rd_valid with response count = issue-acked count, or outside READ, SHALL be ignored.
REQ-019 READ→APPLY when response count reaches 4.
REQ-020 mlu_tiles, mlu_mask, mlu_primary, mlu_secondary SHALL be driven from internal registers at all times.
REQ-021 APPLY (one cycle): tile slots SHALL capture mlu_next; go WRITE.
REQ-022 WRITE: mem_wr_req=1, mem_wr_addr = base+write count, mem_wr_data = slot[write count]; each mem_wr_ack SHALL increment count; at 4 acks go DONE.
REQ-023 Request signals SHALL hold addr/data stable until acked.
REQ-024 DONE (one cycle): done=1; next state IDLE.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W (base 0xFFFF, ADDR_W=16 → 0xFFFF,0x0000,0x0001,0x0002).
REQ-026 Counters SHALL be 3 bits, saturating at 4; no req asserted once count is 4.
REQ-027 Ideal memory (ack same cycle, response cycle after ack): accept at cycle 0, reads 1–4, responses 2–5, APPLY 6, writes 7–10, done at cycle 11.

Reset
REQ-028 Reset SHALL force IDLE; cmd_ready=1; busy, done, mem_rd_req, mem_wr_req=0; counters, tile slots, latched command cleared to 0.
REQ-029 Reset mid-operation SHALL abort; no further requests; in-flight read responses after reset are ignored.
REQ-030 Reset has priority over every simultaneous event including cmd_valid.

Verification
REQ-031 Ideal memory, cmd_addr=0x0010, all masks ones -> reads 0x10..0x13, writes 0x10..0x13 carry mlu_next data, done at cycle 11.
REQ-032 mem_rd_ack low for 3 cycles on first request -> mem_rd_addr holds 0x0010, done delayed by 3 cycles.
REQ-033 cmd_addr=0xFFFE -> addresses 0xFFFE,0xFFFF,0x0000,0x0001 for reads and writes.
REQ-034 cmd_valid held high while busy -> exactly one command accepted per done; next accepted cycle after DONE.
REQ-035 Reset asserted during WRITE after 2 acks -> next cycle mem_wr_req=0, busy=0, cmd_ready=1, done never pulses.
REQ-036 Spurious mem_rd_valid in IDLE with data 0xAA.. -> slots unchanged, state stays IDLE.

Source files
------------

// File: rtl/mlu_ctrl.sv
// Tile read-modify-write sequencer: fetches four framebuffer tiles, lets the
// combinational MLU transform them for one cycle, then writes them back.
module mlu_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [511:0]      cmd_mask,
  input  logic [11:0]       cmd_primary,
  input  logic [11:0]       cmd_secondary,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [767:0]      mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [767:0]      mem_wr_data,
  input  logic              mem_wr_ack,
  output logic [3071:0]     mlu_tiles,
  output logic [511:0]      mlu_mask,
  output logic [11:0]       mlu_primary,
  output logic [11:0]       mlu_secondary,
  input  logic [3071:0]     mlu_next,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, APPLY, WRITE, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [511:0]      mask;
    logic [11:0]       primary;
    logic [11:0]       secondary;
  } cmd_t;

  state_t               state;
  cmd_t                 cmd_q;
  logic [2:0]           iss_cnt, rsp_cnt, wr_cnt;
  logic [3:0][767:0]    slot;
  logic                 rsp_take;

  // Counters saturate at 4, so bit 2 alone marks "all four tiles handled".
  assign mem_rd_req  = (state == READ) && !iss_cnt[2];
  assign mem_rd_addr = cmd_q.addr + ADDR_W'(iss_cnt);
  assign mem_wr_req  = (state == WRITE) && !wr_cnt[2];
  assign mem_wr_addr = cmd_q.addr + ADDR_W'(wr_cnt);
  assign mem_wr_data = slot[wr_cnt[1:0]];

  assign mlu_tiles     = slot;
  assign mlu_mask      = cmd_q.mask;
  assign mlu_primary   = cmd_q.primary;
  assign mlu_secondary = cmd_q.secondary;

  // A response is only meaningful if a matching request was already accepted.
  assign rsp_take = (state == READ) && mem_rd_valid && (rsp_cnt < iss_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_q     <= '0;
      iss_cnt   <= '0;
      rsp_cnt   <= '0;
      wr_cnt    <= '0;
      slot      <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_q     <= {cmd_addr, cmd_mask, cmd_primary, cmd_secondary};
          iss_cnt   <= '0;
          rsp_cnt   <= '0;
          wr_cnt    <= '0;
          state     <= READ;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
        end
        READ: begin
          if (mem_rd_req && mem_rd_ack) iss_cnt <= iss_cnt + 3'd1;
          if (rsp_take) begin
            slot[rsp_cnt[1:0]] <= mem_rd_data;
            rsp_cnt            <= rsp_cnt + 3'd1;
            if (rsp_cnt == 3'd3) state <= APPLY;
          end
        end
        APPLY: begin
          slot  <= mlu_next;
          state <= WRITE;
        end
        WRITE: if (mem_wr_req && mem_wr_ack) begin
          wr_cnt <= wr_cnt + 3'd1;
          if (wr_cnt == 3'd3) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlu_ctrl.sv
// Directed bench for mlu_ctrl: a table of commands run against a small
// memory model, plus hand sequences for reset and back-pressure corners.
module tb_mlu_ctrl;

  localparam logic [767:0] XTILE = {12{64'hF0F0_1234_5678_9ABC}};

  logic           clk, reset;
  logic           cmd_valid, cmd_ready;
  logic [15:0]    cmd_addr;
  logic [511:0]   cmd_mask;
  logic [11:0]    cmd_primary, cmd_secondary;
  logic           mem_rd_req, mem_rd_ack, mem_rd_valid;
  logic [15:0]    mem_rd_addr;
  logic [767:0]   mem_rd_data;
  logic           mem_wr_req, mem_wr_ack;
  logic [15:0]    mem_wr_addr;
  logic [767:0]   mem_wr_data;
  logic [3071:0]  mlu_tiles, mlu_next;
  logic [511:0]   mlu_mask;
  logic [11:0]    mlu_primary, mlu_secondary;
  logic           busy, done;

  mlu_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_mask(cmd_mask), .cmd_primary(cmd_primary), .cmd_secondary(cmd_secondary),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack),
    .mlu_tiles(mlu_tiles), .mlu_mask(mlu_mask), .mlu_primary(mlu_primary),
    .mlu_secondary(mlu_secondary), .mlu_next(mlu_next),
    .busy(busy), .done(done)
  );

  // Stand-in MLU: a fixed per-tile XOR, easy to predict.
  assign mlu_next = mlu_tiles ^ {4{XTILE}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]       addr;
    logic [511:0]      mask;
    logic [11:0]       pri;
    logic [11:0]       sec;
    logic [7:0]        stall;
    logic [3:0][15:0]  exp_addr;
    logic [7:0]        exp_done;
  } vec_t;

  vec_t tbl [5];

  int n_cmp = 0, n_fail = 0;

  // memory model state
  logic         pend_v;
  logic [15:0]  pend_a;
  int           pend_k, stall_left, n_rd, n_wr, n_done, cyc, done_cyc;
  bit           wr_en;
  logic [15:0]  rd_log [8];
  logic [15:0]  wr_log [8];
  logic [767:0] wr_dlog [8];

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [767:0] rd_gen(input logic [15:0] a, input int k);
    logic [7:0] t;
    t = 8'hC0 + 8'(k);
    return {24{a, t, 8'h3C}};
  endfunction

  // Ideal memory: ack in the request cycle (after an optional stall),
  // read data one cycle after the ack.
  task automatic model_eval();
    mem_rd_valid = pend_v;
    mem_rd_data  = rd_gen(pend_a, pend_k);
    pend_v       = 1'b0;
    mem_rd_ack   = 1'b0;
    if (mem_rd_req === 1'b1) begin
      if (stall_left != 0) stall_left--;
      else begin
        mem_rd_ack = 1'b1;
        if (n_rd < 8) rd_log[n_rd] = mem_rd_addr;
        pend_v = 1'b1;
        pend_a = mem_rd_addr;
        pend_k = n_rd;
        n_rd++;
      end
    end
    mem_wr_ack = (mem_wr_req === 1'b1) && wr_en;
    if (mem_wr_ack) begin
      if (n_wr < 8) begin
        wr_log[n_wr]  = mem_wr_addr;
        wr_dlog[n_wr] = mem_wr_data;
      end
      n_wr++;
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
      n_done++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_eval();
  endtask

  task automatic start_cmd(input logic [15:0] a, input logic [511:0] m,
                           input logic [11:0] p, input logic [11:0] s, input int stall);
    cmd_valid = 1'b1; cmd_addr = a; cmd_mask = m; cmd_primary = p; cmd_secondary = s;
    stall_left = stall; n_rd = 0; n_wr = 0; n_done = 0; cyc = 0; done_cyc = -1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    start_cmd(v.addr, v.mask, v.pri, v.sec, int'(v.stall));
    chk($sformatf("v%0d_ready", i), cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 60 && n_done == 0; c++) begin
      if (mem_rd_req && !mem_rd_ack && n_rd == 0)
        chk($sformatf("v%0d_stall_addr", i), mem_rd_addr, v.exp_addr[0]);
      step();
    end
    chk($sformatf("v%0d_done_cyc", i), done_cyc, v.exp_done);
    chk($sformatf("v%0d_nrd", i), n_rd, 4);
    chk($sformatf("v%0d_nwr", i), n_wr, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("v%0d_rd_addr%0d", i, k), rd_log[k], v.exp_addr[k]);
      chk($sformatf("v%0d_wr_addr%0d", i, k), wr_log[k], v.exp_addr[k]);
      chk($sformatf("v%0d_wr_data%0d", i, k), wr_dlog[k], rd_gen(v.exp_addr[k], k) ^ XTILE);
      chk($sformatf("v%0d_tile%0d", i, k), mlu_tiles[768*k +: 768], rd_gen(v.exp_addr[k], k) ^ XTILE);
    end
    chk($sformatf("v%0d_mask", i), mlu_mask, v.mask);
    chk($sformatf("v%0d_pri", i), mlu_primary, v.pri);
    chk($sformatf("v%0d_sec", i), mlu_secondary, v.sec);
    step();
    chk($sformatf("v%0d_idle", i), {done, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    int bad;
    tbl[0] = '{16'h0010, {512{1'b1}}, 12'hF00, 12'h00F, 8'd0,
               {16'h0013, 16'h0012, 16'h0011, 16'h0010}, 8'd11};
    tbl[1] = '{16'h0010, {512{1'b1}}, 12'h123, 12'h456, 8'd3,
               {16'h0013, 16'h0012, 16'h0011, 16'h0010}, 8'd14};
    tbl[2] = '{16'hFFFE, {512{1'b1}}, 12'hABC, 12'h0F0, 8'd0,
               {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, 8'd11};
    tbl[3] = '{16'hFFFF, {512{1'b0}}, 12'h001, 12'hFFE, 8'd1,
               {16'h0002, 16'h0001, 16'h0000, 16'hFFFF}, 8'd12};
    tbl[4] = '{16'h1234, {4{128'hDEADBEEF_01234567_89ABCDEF_5555AAAA}}, 12'h5A5, 12'hA5A, 8'd2,
               {16'h1237, 16'h1236, 16'h1235, 16'h1234}, 8'd13};

    pend_v = 1'b0; pend_a = '0; pend_k = 0; stall_left = 0; wr_en = 1'b1;
    n_rd = 0; n_wr = 0; n_done = 0; cyc = 0; done_cyc = -1;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;

    // reset wins over a simultaneous command
    reset = 1'b1;
    start_cmd(16'h0010, {512{1'b1}}, 12'h111, 12'h222, 0);
    step(); step();
    cmd_valid = 1'b0;
    reset = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_wr_req", mem_wr_req, 0);
    chk("rst_mask", mlu_mask, 0);
    chk("rst_pri", mlu_primary, 0);
    chk("rst_tile0", mlu_tiles[767:0], 0);

    // spurious read data while idle
    mem_rd_valid = 1'b1;
    mem_rd_data  = {96{8'hAA}};
    step();
    chk("spur_tile0", mlu_tiles[767:0], 0);
    chk("spur_tile3", mlu_tiles[3071:2304], 0);
    chk("spur_idle", {busy, cmd_ready}, 2'b01);

    for (int i = 0; i < 5; i++) run_vec(i);

    // command held high while busy, then reset aborts the second one mid-read
    start_cmd(16'h0020, {512{1'b1}}, 12'h321, 12'h654, 0);
    bad = 0;
    for (int c = 0; c < 60 && n_done == 0; c++) begin
      step();
      if (cmd_ready) bad++;
    end
    chk("hold_ready_busy", bad, 0);
    chk("hold_done_cyc", done_cyc, 11);
    step();
    chk("hold_ready_after", cmd_ready, 1);
    step();
    chk("hold_second_busy", {busy, cmd_ready, mem_rd_req}, 3'b101);
    chk("hold_second_addr", mem_rd_addr, 16'h0020);
    reset = 1'b1;
    cmd_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("rdabort_state", {busy, cmd_ready, mem_rd_req, mem_wr_req}, 4'b0100);
    step();
    chk("rdabort_tile0", mlu_tiles[767:0], 0);
    chk("rdabort_mask", mlu_mask, 0);

    // reset during write after two acks
    start_cmd(16'h0040, {512{1'b1}}, 12'h777, 12'h888, 0);
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 60 && n_wr < 2; c++) step();
    chk("wrabort_cyc", cyc, 8);
    wr_en = 1'b0;
    step();
    chk("wrabort_pre_req", mem_wr_req, 1);
    chk("wrabort_pre_addr", mem_wr_addr, 16'h0042);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wrabort_post", {mem_wr_req, busy, cmd_ready}, 3'b001);
    repeat (4) step();
    chk("wrabort_no_done", n_done, 0);
    wr_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
